// File: rtl/pll_lock_seq.sv
// PLL lock sequencer: pulses the PLL reset, waits for a stable lock and holds the
// downstream ready while locked. Output-divider changes are applied through a re-lock.
module pll_lock_seq #(
   parameter int unsigned RESET_PULSE_CYCLES  = 16,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
   parameter int unsigned ODIV_DEFAULT        = 9
) (
   input  logic       I_clk,
   input  logic       I_rst_n,
   input  logic       I_pll_lock,
   input  logic       I_restart,
   input  logic       I_cfg_req,
   input  logic [6:0] I_cfg_odiv,
   output logic       O_cfg_ack,
   output logic       O_pll_reset,
   output logic [6:0] O_odsel,
   output logic       O_ready,
   output logic       O_timeout,
   output logic [7:0] O_loss_cnt
);

   localparam int unsigned PULSE_W  = $clog2(RESET_PULSE_CYCLES + 1);
   localparam int unsigned STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int unsigned TMO_W    = $clog2(LOCK_TIMEOUT_CYCLES + 1);

   localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(RESET_PULSE_CYCLES - 1);
   localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [6:0]          ODSEL_RST   = 7'(ODIV_DEFAULT);

   typedef enum logic [1:0] {StRstPulse, StWaitLock, StRun} state_e;

   state_e              state_q, state_d;
   logic [PULSE_W-1:0]  pulse_q, pulse_d;
   logic [STABLE_W-1:0] stable_q, stable_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                timeout_q, timeout_d;
   logic [7:0]          loss_q, loss_d;
   logic [6:0]          odsel_q, odsel_d;
   logic [1:0]          sync_q;
   logic                lock_s;
   logic                cfg_take;

   assign lock_s = sync_q[1];

   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], I_pll_lock};
      end
   end

   // Lock loss takes priority over a divider change in the same RUN cycle.
   assign cfg_take = (state_q == StRun) && lock_s && I_cfg_req;

   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         state_q   <= StRstPulse;
         pulse_q   <= '0;
         stable_q  <= '0;
         tmo_q     <= '0;
         timeout_q <= 1'b0;
         loss_q    <= '0;
         odsel_q   <= ODSEL_RST;
      end else begin
         state_q   <= state_d;
         pulse_q   <= pulse_d;
         stable_q  <= stable_d;
         tmo_q     <= tmo_d;
         timeout_q <= timeout_d;
         loss_q    <= loss_d;
         odsel_q   <= odsel_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pulse_d   = '0;
      stable_d  = '0;
      tmo_d     = '0;
      timeout_d = timeout_q;
      loss_d    = loss_q;
      odsel_d   = odsel_q;
      unique case (state_q)
         StRstPulse: begin
            if (pulse_q == PULSE_LAST) begin
               state_d = StWaitLock;
            end else begin
               pulse_d = pulse_q + 1'b1;
            end
         end
         StWaitLock: begin
            if (lock_s && (stable_q == STABLE_LAST)) begin
               state_d = StRun;
            end else if (tmo_q == TMO_LAST) begin
               state_d   = StRstPulse;
               timeout_d = 1'b1;
            end else begin
               stable_d = lock_s ? stable_q + 1'b1 : '0;
               tmo_d    = tmo_q + 1'b1;
            end
         end
         StRun: begin
            if (!lock_s) begin
               state_d = StRstPulse;
               if (loss_q != 8'hFF) begin
                  loss_d = loss_q + 8'd1;
               end
            end else if (cfg_take) begin
               state_d = StRstPulse;
               odsel_d = (I_cfg_odiv == 7'd0) ? 7'd1 : I_cfg_odiv;
            end
         end
         default: state_d = StRstPulse;
      endcase
      // A restart always begins a fresh full-width pulse, whatever else happened.
      if (I_restart) begin
         state_d  = StRstPulse;
         pulse_d  = '0;
         stable_d = '0;
         tmo_d    = '0;
      end
   end

   always_comb begin
      O_pll_reset = (state_q == StRstPulse);
      O_ready     = (state_q == StRun);
      O_cfg_ack   = I_rst_n && cfg_take;
      O_odsel     = odsel_q;
      O_timeout   = timeout_q;
      O_loss_cnt  = loss_q;
   end

endmodule

// File: tb/tb_pll_lock_seq.sv
// Self-checking bench for pll_lock_seq with short pulse/stable/timeout parameters.
module tb_pll_lock_seq;

   localparam int PULSE   = 4;
   localparam int STABLE  = 8;
   localparam int TIMEOUT = 64;

   logic       I_clk = 1'b0;
   logic       I_rst_n;
   logic       I_pll_lock;
   logic       I_restart;
   logic       I_cfg_req;
   logic [6:0] I_cfg_odiv;
   logic       O_cfg_ack;
   logic       O_pll_reset;
   logic [6:0] O_odsel;
   logic       O_ready;
   logic       O_timeout;
   logic [7:0] O_loss_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_loss = 0;
   logic [6:0] exp_odsel_q[$];
   bit glitch_en = 1'b0;

   always #5 I_clk = ~I_clk;

   pll_lock_seq #(
      .RESET_PULSE_CYCLES (PULSE),
      .LOCK_STABLE_CYCLES (STABLE),
      .LOCK_TIMEOUT_CYCLES(TIMEOUT),
      .ODIV_DEFAULT       (9)
   ) dut (
      .I_clk      (I_clk),
      .I_rst_n    (I_rst_n),
      .I_pll_lock (I_pll_lock),
      .I_restart  (I_restart),
      .I_cfg_req  (I_cfg_req),
      .I_cfg_odiv (I_cfg_odiv),
      .O_cfg_ack  (O_cfg_ack),
      .O_pll_reset(O_pll_reset),
      .O_odsel    (O_odsel),
      .O_ready    (O_ready),
      .O_timeout  (O_timeout),
      .O_loss_cnt (O_loss_cnt)
   );

   // Called at a sample point (negedge + 1). Waits for a reset pulse, returns its width in
   // cycles and the number of cycles spent between pulse end and ready (or the next pulse).
   task automatic measure(output int pw, output int wl, output bit rdy_at_pulse);
      int n;
      pw = 0;
      wl = 0;
      n  = 0;
      while (!O_pll_reset && n < 200) begin
         @(negedge I_clk); #1;
         n++;
      end
      rdy_at_pulse = O_ready;
      while (O_pll_reset && pw < 200) begin
         pw++;
         @(negedge I_clk); #1;
      end
      while (!O_ready && !O_pll_reset && wl < 200) begin
         wl++;
         @(negedge I_clk); #1;
      end
   endtask

   task automatic test_reset();
      int pw, wl;
      bit rdy;
      I_rst_n    = 1'b0;
      I_pll_lock = 1'b1;
      I_restart  = 1'b0;
      I_cfg_req  = 1'b0;
      I_cfg_odiv = 7'd0;
      repeat (3) @(negedge I_clk);
      #1;
      n_checks++; if (O_pll_reset !== 1'b1) begin n_fail++; $display("FAIL rst_pll_reset: got %b want 1", O_pll_reset); end
      n_checks++; if (O_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", O_ready); end
      n_checks++; if (O_cfg_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", O_cfg_ack); end
      n_checks++; if (O_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b want 0", O_timeout); end
      n_checks++; if (O_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_loss: got %0d want 0", O_loss_cnt); end
      n_checks++; if (O_odsel !== 7'd9) begin n_fail++; $display("FAIL rst_odsel: got %0d want 9", O_odsel); end
      I_rst_n = 1'b1;
      measure(pw, wl, rdy);
      n_checks++; if (pw != PULSE) begin n_fail++; $display("FAIL rst_pulse_width: got %0d want %0d", pw, PULSE); end
      n_checks++; if (wl != STABLE) begin n_fail++; $display("FAIL rst_lock_wait: got %0d want %0d", wl, STABLE); end
      n_checks++; if (O_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", O_ready); end
   endtask

   task automatic test_loss();
      int pw, wl;
      bit rdy;
      I_pll_lock = 1'b0;
      if (exp_loss < 255) exp_loss++;
      @(negedge I_clk);
      I_pll_lock = 1'b1;
      #1;
      measure(pw, wl, rdy);
      n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL loss_ready_fall: got %b want 0", rdy); end
      n_checks++; if (pw != PULSE) begin n_fail++; $display("FAIL loss_pulse_width: got %0d want %0d", pw, PULSE); end
      n_checks++; if (wl != STABLE) begin n_fail++; $display("FAIL loss_relock_wait: got %0d want %0d", wl, STABLE); end
      n_checks++; if (O_loss_cnt !== 8'(exp_loss)) begin n_fail++; $display("FAIL loss_count: got %0d want %0d", O_loss_cnt, exp_loss); end
   endtask

   task automatic test_glitch();
      int pw, wl;
      bit rdy;
      glitch_en = 1'b1;
      if (exp_loss < 255) exp_loss++;
      fork
         begin
            int k;
            k = 0;
            while (glitch_en) begin
               @(negedge I_clk);
               if (glitch_en) I_pll_lock = ((k % 5) != 0);
               k++;
            end
         end
      join_none
      for (int r = 0; r < 2; r++) begin
         measure(pw, wl, rdy);
         n_checks++; if (pw != PULSE) begin n_fail++; $display("FAIL glitch_pulse_width[%0d]: got %0d want %0d", r, pw, PULSE); end
         n_checks++; if (wl != TIMEOUT) begin n_fail++; $display("FAIL glitch_timeout_wait[%0d]: got %0d want %0d", r, wl, TIMEOUT); end
         n_checks++; if (O_timeout !== 1'b1) begin n_fail++; $display("FAIL glitch_timeout_flag[%0d]: got %b want 1", r, O_timeout); end
      end
      glitch_en  = 1'b0;
      I_pll_lock = 1'b1;
      measure(pw, wl, rdy);
      n_checks++; if (wl != STABLE) begin n_fail++; $display("FAIL glitch_relock_wait: got %0d want %0d", wl, STABLE); end
      n_checks++; if (O_timeout !== 1'b1) begin n_fail++; $display("FAIL glitch_timeout_sticky: got %b want 1", O_timeout); end
      n_checks++; if (O_loss_cnt !== 8'(exp_loss)) begin n_fail++; $display("FAIL glitch_loss_count: got %0d want %0d", O_loss_cnt, exp_loss); end
   endtask

   task automatic test_cfg();
      int ods [3];
      bit rss [3];
      int pw, wl;
      bit rdy;
      logic [6:0] e;
      ods = '{20, 0, 127};
      rss = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         I_cfg_req  = 1'b1;
         I_cfg_odiv = 7'(ods[i]);
         I_restart  = rss[i];
         exp_odsel_q.push_back((ods[i] == 0) ? 7'd1 : 7'(ods[i]));
         #1;
         n_checks++; if (O_cfg_ack !== 1'b1) begin n_fail++; $display("FAIL cfg_ack[%0d]: got %b want 1", i, O_cfg_ack); end
         @(negedge I_clk);
         I_restart = 1'b0;
         #1;
         n_checks++; if (O_cfg_ack !== 1'b0) begin n_fail++; $display("FAIL cfg_ack_single[%0d]: got %b want 0", i, O_cfg_ack); end
         e = (exp_odsel_q.size() > 0) ? exp_odsel_q.pop_front() : 7'd0;
         n_checks++; if (O_odsel !== e) begin n_fail++; $display("FAIL cfg_odsel[%0d]: got %0d want %0d", i, O_odsel, e); end
         I_cfg_req = 1'b0;
         measure(pw, wl, rdy);
         n_checks++; if (pw != PULSE) begin n_fail++; $display("FAIL cfg_pulse_width[%0d]: got %0d want %0d", i, pw, PULSE); end
         n_checks++; if (wl != STABLE) begin n_fail++; $display("FAIL cfg_relock_wait[%0d]: got %0d want %0d", i, wl, STABLE); end
      end
   endtask

   task automatic test_pending();
      int pw, wl, n, early;
      bit rdy;
      logic [6:0] e;
      // Request raised outside RUN must wait for the first RUN cycle.
      I_restart = 1'b1;
      @(negedge I_clk);
      I_restart  = 1'b0;
      I_cfg_req  = 1'b1;
      I_cfg_odiv = 7'd33;
      exp_odsel_q.push_back(7'd33);
      #1;
      n = 0;
      early = 0;
      while (!O_ready && n < 100) begin
         if (O_cfg_ack) early++;
         @(negedge I_clk); #1;
         n++;
      end
      n_checks++; if (early != 0) begin n_fail++; $display("FAIL pend_early_ack: got %0d want 0", early); end
      n_checks++; if (O_cfg_ack !== 1'b1) begin n_fail++; $display("FAIL pend_ack_first_run: got %b want 1", O_cfg_ack); end
      @(negedge I_clk); #1;
      e = (exp_odsel_q.size() > 0) ? exp_odsel_q.pop_front() : 7'd0;
      n_checks++; if (O_odsel !== e) begin n_fail++; $display("FAIL pend_odsel: got %0d want %0d", O_odsel, e); end
      I_cfg_req = 1'b0;
      measure(pw, wl, rdy);
      n_checks++; if (wl != STABLE) begin n_fail++; $display("FAIL pend_relock_wait: got %0d want %0d", wl, STABLE); end
      // Lock loss and request in the same RUN cycle: loss wins, request stays pending.
      I_pll_lock = 1'b0;
      if (exp_loss < 255) exp_loss++;
      @(negedge I_clk);
      I_pll_lock = 1'b1;
      @(negedge I_clk);
      I_cfg_req  = 1'b1;
      I_cfg_odiv = 7'd50;
      exp_odsel_q.push_back(7'd50);
      #1;
      n_checks++; if (O_cfg_ack !== 1'b0) begin n_fail++; $display("FAIL loss_vs_cfg_ack: got %b want 0", O_cfg_ack); end
      n = 0;
      while (!O_pll_reset && n < 20) begin
         @(negedge I_clk); #1;
         n++;
      end
      early = 0;
      while (!O_ready && n < 100) begin
         if (O_cfg_ack) early++;
         @(negedge I_clk); #1;
         n++;
      end
      n_checks++; if (early != 0) begin n_fail++; $display("FAIL loss_vs_cfg_early_ack: got %0d want 0", early); end
      n_checks++; if (O_cfg_ack !== 1'b1) begin n_fail++; $display("FAIL loss_vs_cfg_served: got %b want 1", O_cfg_ack); end
      n_checks++; if (O_loss_cnt !== 8'(exp_loss)) begin n_fail++; $display("FAIL loss_vs_cfg_count: got %0d want %0d", O_loss_cnt, exp_loss); end
      @(negedge I_clk); #1;
      e = (exp_odsel_q.size() > 0) ? exp_odsel_q.pop_front() : 7'd0;
      n_checks++; if (O_odsel !== e) begin n_fail++; $display("FAIL loss_vs_cfg_odsel: got %0d want %0d", O_odsel, e); end
      I_cfg_req = 1'b0;
      measure(pw, wl, rdy);
      n_checks++; if (O_ready !== 1'b1) begin n_fail++; $display("FAIL loss_vs_cfg_ready: got %b want 1", O_ready); end
   endtask

   task automatic test_restart();
      int pw, wl;
      bit rdy;
      I_restart = 1'b1;
      @(negedge I_clk);
      I_restart = 1'b0;
      #1;
      // Second restart one cycle into the pulse stretches it by that cycle plus one.
      @(negedge I_clk);
      I_restart = 1'b1;
      #1;
      @(negedge I_clk);
      I_restart = 1'b0;
      #1;
      measure(pw, wl, rdy);
      n_checks++; if (pw + 2 != PULSE + 2) begin n_fail++; $display("FAIL restart_pulse_width: got %0d want %0d", pw + 2, PULSE + 2); end
      n_checks++; if (wl != STABLE) begin n_fail++; $display("FAIL restart_relock_wait: got %0d want %0d", wl, STABLE); end
      n_checks++; if (O_timeout !== 1'b1) begin n_fail++; $display("FAIL restart_timeout_kept: got %b want 1", O_timeout); end
      n_checks++; if (O_loss_cnt !== 8'(exp_loss)) begin n_fail++; $display("FAIL restart_loss_kept: got %0d want %0d", O_loss_cnt, exp_loss); end
   endtask

   task automatic test_saturate();
      int pw, wl, bad;
      bit rdy;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         I_pll_lock = 1'b0;
         if (exp_loss < 255) exp_loss++;
         @(negedge I_clk);
         I_pll_lock = 1'b1;
         #1;
         measure(pw, wl, rdy);
         if (pw != PULSE || wl != STABLE || !O_ready) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL sat_relock_cycles: got %0d bad want 0", bad); end
      n_checks++; if (O_loss_cnt !== 8'(exp_loss)) begin n_fail++; $display("FAIL sat_loss_count: got %0d want %0d", O_loss_cnt, exp_loss); end
      n_checks++; if (O_loss_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_loss_255: got %0d want 255", O_loss_cnt); end
   endtask

   task automatic test_reset_in_run();
      int pw, wl;
      bit rdy;
      I_cfg_req  = 1'b1;
      I_cfg_odiv = 7'd77;
      I_rst_n    = 1'b0;
      #1;
      n_checks++; if (O_cfg_ack !== 1'b0) begin n_fail++; $display("FAIL rir_ack_during: got %b want 0", O_cfg_ack); end
      @(negedge I_clk); #1;
      n_checks++; if (O_pll_reset !== 1'b1) begin n_fail++; $display("FAIL rir_pll_reset: got %b want 1", O_pll_reset); end
      n_checks++; if (O_ready !== 1'b0) begin n_fail++; $display("FAIL rir_ready: got %b want 0", O_ready); end
      n_checks++; if (O_cfg_ack !== 1'b0) begin n_fail++; $display("FAIL rir_ack: got %b want 0", O_cfg_ack); end
      n_checks++; if (O_timeout !== 1'b0) begin n_fail++; $display("FAIL rir_timeout: got %b want 0", O_timeout); end
      n_checks++; if (O_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL rir_loss: got %0d want 0", O_loss_cnt); end
      n_checks++; if (O_odsel !== 7'd9) begin n_fail++; $display("FAIL rir_odsel: got %0d want 9", O_odsel); end
      I_cfg_req = 1'b0;
      exp_loss  = 0;
      @(negedge I_clk);
      I_rst_n = 1'b1;
      #1;
      measure(pw, wl, rdy);
      n_checks++; if (pw != PULSE) begin n_fail++; $display("FAIL rir_pulse_width: got %0d want %0d", pw, PULSE); end
      n_checks++; if (wl != STABLE) begin n_fail++; $display("FAIL rir_relock_wait: got %0d want %0d", wl, STABLE); end
      n_checks++; if (exp_odsel_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d want 0", exp_odsel_q.size()); end
   endtask

   initial begin
      test_reset();
      test_loss();
      test_glitch();
      test_cfg();
      test_pending();
      test_restart();
      test_saturate();
      test_reset_in_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pll_lock_seq.md
PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

Interface
REQ-001 SHALL have parameter RESET_PULSE_CYCLES, default 16: PLL reset pulse width, in I_clk cycles.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: cycles of continuous lock required before ready.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: maximum wait for stable lock before retry.
REQ-004 SHALL have parameter ODIV_DEFAULT, default 9: output divider value applied after reset.
REQ-005 SHALL have port I_clk, input, 1 bit: single clock, the free-running PLL reference clock.
REQ-006 SHALL have port I_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port I_pll_lock, input, 1 bit: PLL lock, asynchronous to I_clk.
REQ-008 SHALL have port I_restart, input, 1 bit: single-cycle pulse requesting a full PLL re-lock.
REQ-009 SHALL have port I_cfg_req, input, 1 bit: divider-change request, level, held until ack.
REQ-010 SHALL have port I_cfg_odiv, input, 7 bits: requested output divider value.
REQ-011 SHALL have port O_cfg_ack, output, 1 bit: one-cycle acceptance pulse.
REQ-012 SHALL have port O_pll_reset, output, 1 bit: drives the PLL RESET pin, active-high.
REQ-013 SHALL have port O_odsel, output, 7 bits: drives the PLL ODSEL0 pin.
REQ-014 SHALL have port O_ready, output, 1 bit: PLL output usable; downstream logic is released from reset while high.
REQ-015 SHALL have port O_timeout, output, 1 bit: sticky lock-timeout flag.
REQ-016 SHALL have port O_loss_cnt, output, 8 bits: saturating count of lock losses seen in RUN.

Function
REQ-017 SHALL pass I_pll_lock through a 2-flop synchronizer; the synchronized value is lock_s, and all uses below refer to lock_s.
REQ-018 SHALL implement the states RST_PULSE, WAIT_LOCK and RUN, all registered.
REQ-019 In RST_PULSE, O_pll_reset SHALL be 1 for exactly RESET_PULSE_CYCLES cycles, then the FSM SHALL enter WAIT_LOCK.
REQ-020 O_pll_reset SHALL be 0 in all states other than RST_PULSE.
REQ-021 In WAIT_LOCK, the stable counter SHALL increment while lock_s=1 and clear to 0 on any cycle with lock_s=0.
REQ-022 When the stable counter reaches LOCK_STABLE_CYCLES, the FSM SHALL enter RUN.
REQ-023 In WAIT_LOCK, the timeout counter SHALL count every cycle from entry.
REQ-024 When the timeout counter reaches LOCK_TIMEOUT_CYCLES before RUN is reached, the block SHALL set O_timeout=1 and enter RST_PULSE.
REQ-025 O_ready SHALL be 1 only while in RUN; it SHALL rise on the first RUN cycle and fall on the cycle the FSM leaves RUN.
REQ-026 In RUN, lock_s=0 SHALL cause: O_loss_cnt incremented (saturating at 255), then entry to RST_PULSE.
REQ-027 In RUN, I_cfg_req=1 SHALL cause, in the same cycle: O_cfg_ack pulse; O_odsel loaded with I_cfg_odiv on the next edge; entry to RST_PULSE.
REQ-028 When REQ-027 loads O_odsel, an I_cfg_odiv value of 0 SHALL load 1.
REQ-029 I_cfg_req SHALL NOT be acked outside RUN; a pending request SHALL be served on the first RUN cycle.
REQ-030 When lock_s=0 and I_cfg_req=1 in the same RUN cycle, lock loss SHALL win: loss counted, no ack, request stays pending.
REQ-031 When I_restart=1 and I_cfg_req=1 in the same RUN cycle, the cfg request SHALL be acked and applied; a single RST_PULSE follows.
REQ-032 I_restart=1 in any state SHALL enter RST_PULSE with the pulse counter restarted; O_timeout and O_loss_cnt SHALL be unaffected.
REQ-033 O_odsel SHALL change only on a cfg acceptance or on reset.
REQ-034 O_cfg_ack SHALL never be high for two consecutive cycles.
REQ-035 O_timeout SHALL clear only on reset.

Reset
REQ-036 While I_rst_n=0 at a rising edge, the block SHALL set: state=RST_PULSE, O_pll_reset=1, O_ready=0, O_cfg_ack=0, O_timeout=0, O_loss_cnt=0, O_odsel=ODIV_DEFAULT, all counters 0, synchronizer flops 0.
REQ-037 After I_rst_n returns to 1, the pulse SHALL last RESET_PULSE_CYCLES cycles.
REQ-038 Reset asserted mid-operation, including in RUN with a cfg pending, SHALL abort immediately with no ack issued.

Verification (bench parameters: PULSE=4, STABLE=8, TIMEOUT=64)
REQ-039 Bench SHALL cover: reset release, then lock held high -> O_pll_reset high 4 cycles; O_ready rises 8 cycles after lock_s first =1.
REQ-040 Bench SHALL cover: lock glitching low every 5 cycles -> O_ready stays 0; O_timeout=1 and a new 4-cycle reset pulse 64 cycles after WAIT_LOCK entry.
REQ-041 Bench SHALL cover: in RUN, lock dropped for 1 cycle -> O_ready falls; O_loss_cnt=1; reset pulse; re-lock.
REQ-042 Bench SHALL cover: in RUN, I_cfg_req=1 with I_cfg_odiv=20 -> 1-cycle ack; O_odsel=20; reset pulse; ready after re-lock. Repeat with odiv=0 -> O_odsel=1.
REQ-043 Bench SHALL cover: cfg_req held during WAIT_LOCK -> no ack until the first RUN cycle. Also: lock loss and cfg_req in the same cycle -> no ack, loss counted.
REQ-044 Bench SHALL cover: 300 forced lock losses -> O_loss_cnt saturates at 255. Also: I_rst_n=0 in RUN -> all outputs at reset values on the next edge.
